vram_arbiter: RTL and testbench

//  Shares the single-port 16-bit video memory between the text-mode pixel pipeline and a host port.

---
 rtl/vram_pkg.sv | 27 ++
 rtl/vram_wr_fifo.sv | 81 ++++++++
 rtl/vram_arbiter.sv | 142 ++++++++++++++
 tb/tb_vram_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter.
// Holds the memory map, the bus widths, the read FSM state type, the posted-write FIFO
// entry layout, and a helper that classifies an address as glyph space.
package vram_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 14;

    // Text cells live in the low 8K words; glyph rows start at 0x2000.
    localparam logic [ADDR_W-1:0] VRAM_TEXT_BASE  = 14'h0000;
    localparam logic [ADDR_W-1:0] VRAM_GLYPH_BASE = 14'h2000;

    typedef enum logic {
        StIdle   = 1'b0,
        StRdWait = 1'b1
    } vram_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    function automatic logic is_glyph_addr(input logic [ADDR_W-1:0] addr);
        return addr >= VRAM_GLYPH_BASE;
    endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Posted-write FIFO for the VRAM arbiter.
// Synchronous FIFO of {addr, data} entries. DEPTH must be a power of two and at least 2 so
// the pointers wrap naturally.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset (clears pointers and count)
//   push_i                write push_addr_i/push_data_i at the tail (ignored when full)
//   pop_i                 drop the head entry (ignored when empty)
//   full_o, empty_o       occupancy flags
//   head_addr_o/data_o    current head entry
module vram_wr_fifo
    import vram_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_data_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

    wr_entry_t     mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            push_ok;
    logic            pop_ok;

    always_comb begin
        full_o  = (count_q == FullCnt);
        empty_o = (count_q == '0);
        push_ok = push_i && !full_o;
        pop_ok  = pop_i && !empty_o;

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            wptr_d = wptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase

        head_addr_o = mem_q[rptr_q].addr;
        head_data_o = mem_q[rptr_q].data;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok && !rst_i) begin
            mem_q[wptr_q] <= '{addr: push_addr_i, data: push_data_i};
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares the single-port 16-bit video memory between the text-mode display
// pipeline and a host port.
// The display takes the memory combinationally whenever disp_busy_i is high. Host writes are
// posted into a FIFO and drained in free cycles; host reads wait until the FIFO is empty, so
// they are ordered behind every earlier write.
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   disp_busy_i, disp_addr_i             display request and address
//   host_wr_req_i/addr_i/data_i          posted write; accepted when wr_ready_o is high
//   wr_ready_o                           FIFO not full and not in reset
//   host_rd_req_i, host_rd_addr_i        read request, held until rd_valid_o
//   rd_valid_o, host_rdata_o             one-cycle read return, data held until next return
//   wp_err_o                             sticky flag for writes dropped by glyph protection
//   mem_addr_o, mem_we_o, mem_wdata_o    memory command
//   mem_rdata_i                          memory read data, one cycle after the address
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GLYPH_WP   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              disp_busy_i,
    input  logic [ADDR_W-1:0] disp_addr_i,
    input  logic              host_wr_req_i,
    input  logic [ADDR_W-1:0] host_wr_addr_i,
    input  logic [DATA_W-1:0] host_wr_data_i,
    output logic              wr_ready_o,
    input  logic              host_rd_req_i,
    input  logic [ADDR_W-1:0] host_rd_addr_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic              wp_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    vram_state_e       state_q, state_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              wp_err_q, wp_err_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W-1:0] fifo_head_addr;
    logic [DATA_W-1:0] fifo_head_data;
    logic              fifo_push;
    logic              fifo_pop;

    logic              wr_fire;
    logic              wp_hit;
    logic              free_slot;
    logic              rd_issue;

    vram_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (fifo_push),
        .push_addr_i (host_wr_addr_i),
        .push_data_i (host_wr_data_i),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_addr_o (fifo_head_addr),
        .head_data_o (fifo_head_data)
    );

    // Write acceptance and glyph write protection.
    always_comb begin
        wr_ready_o = !fifo_full && !rst_i;
        wr_fire    = host_wr_req_i && wr_ready_o;
        // A protected write is still handshaken, it just never reaches the FIFO.
        wp_hit     = (GLYPH_WP != 0) && is_glyph_addr(host_wr_addr_i);
        fifo_push  = wr_fire && !wp_hit;
        wp_err_d   = wp_err_q || (wr_fire && wp_hit);
    end

    // Memory mux: display first, then pending writes, then a new read.
    always_comb begin
        // Nothing may touch memory during reset so a cleared FIFO is never written.
        free_slot   = !disp_busy_i && !rst_i;
        fifo_pop    = free_slot && !fifo_empty;
        rd_issue    = free_slot && fifo_empty && (state_q == StIdle) && host_rd_req_i;

        mem_addr_o  = VRAM_TEXT_BASE;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        if (disp_busy_i) begin
            mem_addr_o = disp_addr_i;
        end else if (fifo_pop) begin
            mem_addr_o  = fifo_head_addr;
            mem_we_o    = 1'b1;
            mem_wdata_o = fifo_head_data;
        end else if (rd_issue) begin
            mem_addr_o = host_rd_addr_i;
        end
    end

    // Read FSM: the issued read returns regardless of what the mux does during RD_WAIT.
    always_comb begin
        state_d      = state_q;
        rd_valid_d   = 1'b0;
        host_rdata_d = host_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (rd_issue) begin
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                host_rdata_d = mem_rdata_i;
                rd_valid_d   = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            rd_valid_q   <= 1'b0;
            host_rdata_q <= '0;
            wp_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_valid_q   <= rd_valid_d;
            host_rdata_q <= host_rdata_d;
            wp_err_q     <= wp_err_d;
        end
    end

    assign rd_valid_o   = rd_valid_q;
    assign host_rdata_o = host_rdata_q;
    assign wp_err_o     = wp_err_q;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        disp_busy = 1'b0;
    logic [13:0] disp_addr = 14'h0;
    logic        host_wr_req = 1'b0;
    logic [13:0] host_wr_addr = 14'h0;
    logic [15:0] host_wr_data = 16'h0;
    logic        wr_ready;
    logic        host_rd_req = 1'b0;
    logic [13:0] host_rd_addr = 14'h0;
    logic        rd_valid;
    logic [15:0] host_rdata;
    logic        wp_err;
    logic [13:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0;

    logic        pre_we = 1'b0;
    logic [13:0] pre_addr = 14'h0;
    logic [15:0] pre_data = 16'h0;
    logic [15:0] vmem [0:16383];

    int total = 0;
    int bad = 0;

    vram_arbiter #(
        .FIFO_DEPTH (4),
        .GLYPH_WP   (1)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .disp_busy_i    (disp_busy),
        .disp_addr_i    (disp_addr),
        .host_wr_req_i  (host_wr_req),
        .host_wr_addr_i (host_wr_addr),
        .host_wr_data_i (host_wr_data),
        .wr_ready_o     (wr_ready),
        .host_rd_req_i  (host_rd_req),
        .host_rd_addr_i (host_rd_addr),
        .rd_valid_o     (rd_valid),
        .host_rdata_o   (host_rdata),
        .wp_err_o       (wp_err),
        .mem_addr_o     (mem_addr),
        .mem_we_o       (mem_we),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory, read data one cycle after the address.
    always @(posedge clk) begin
        if (pre_we) vmem[pre_addr] <= pre_data;
        else if (mem_we) vmem[mem_addr] <= mem_wdata;
        mem_rdata <= vmem[mem_addr];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        total++; if (host_rdata !== 16'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0000", host_rdata); end
        total++; if (wp_err !== 1'b0) begin bad++; $display("FAIL reset_wp_err: got %b want 0", wp_err); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        cyc();
        rst = 1'b0;
        @(negedge clk);
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL post_reset_wr_ready: got %b want 1", wr_ready); end
    endtask

    task automatic test_write();
        cyc();
        host_wr_req = 1'b1; host_wr_addr = 14'h0105; host_wr_data = 16'h4F41;
        @(negedge clk);
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL wr_accept: got %b want 1", wr_ready); end
        cyc();
        host_wr_req = 1'b0;
        @(negedge clk);
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL wr_mem_we: got %b want 1", mem_we); end
        total++; if (mem_addr !== 14'h0105) begin bad++; $display("FAIL wr_mem_addr: got %h want 0105", mem_addr); end
        total++; if (mem_wdata !== 16'h4F41) begin bad++; $display("FAIL wr_mem_wdata: got %h want 4f41", mem_wdata); end
        cyc();
        @(negedge clk);
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL wr_single_pop: got %b want 0", mem_we); end
    endtask

    task automatic test_read();
        cyc();
        pre_we = 1'b1; pre_addr = 14'h0010; pre_data = 16'h1234;
        cyc();
        pre_we = 1'b0;
        host_rd_req = 1'b1; host_rd_addr = 14'h0010;
        @(negedge clk);
        total++; if (mem_addr !== 14'h0010 || mem_we !== 1'b0) begin bad++; $display("FAIL rd_issue: got addr %h we %b want 0010 0", mem_addr, mem_we); end
        cyc();
        @(negedge clk);
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rd_early: got %b want 0", rd_valid); end
        cyc();
        host_rd_req = 1'b0;
        @(negedge clk);
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL rd_valid_n2: got %b want 1", rd_valid); end
        total++; if (host_rdata !== 16'h1234) begin bad++; $display("FAIL rd_data: got %h want 1234", host_rdata); end
        cyc();
        @(negedge clk);
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rd_pulse: got %b want 0", rd_valid); end
        total++; if (host_rdata !== 16'h1234) begin bad++; $display("FAIL rd_hold: got %h want 1234", host_rdata); end
    endtask

    task automatic test_disp_stall();
        logic saw_we;
        saw_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            disp_busy = 1'b1; disp_addr = 14'h0777;
            host_wr_req = 1'b1; host_wr_addr = 14'h0100 + 14'(i); host_wr_data = 16'hB000 + 16'(i);
            @(negedge clk);
            total++; if (wr_ready !== (i < 4)) begin bad++; $display("FAIL stall_wr_ready%0d: got %b want %b", i, wr_ready, (i < 4)); end
            if (mem_we) saw_we = 1'b1;
        end
        total++; if (mem_addr !== 14'h0777) begin bad++; $display("FAIL stall_disp_addr: got %h want 0777", mem_addr); end
        for (int i = 0; i < 5; i++) begin
            cyc();
            host_wr_req = 1'b0;
            @(negedge clk);
            if (mem_we) saw_we = 1'b1;
        end
        total++; if (saw_we !== 1'b0) begin bad++; $display("FAIL stall_mem_we: got %b want 0", saw_we); end
        cyc();
        disp_busy = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            total++;
            if (mem_we !== 1'b1 || mem_addr !== 14'h0100 + 14'(j) || mem_wdata !== 16'hB000 + 16'(j)) begin
                bad++;
                $display("FAIL drain%0d: got we %b addr %h data %h want 1 %h %h", j, mem_we, mem_addr,
                         mem_wdata, 14'h0100 + 14'(j), 16'hB000 + 16'(j));
            end
            cyc();
        end
        @(negedge clk);
        total++; if (mem_we !== 1'b0 || wr_ready !== 1'b1) begin bad++; $display("FAIL drain_done: got we %b rdy %b want 0 1", mem_we, wr_ready); end
    endtask

    task automatic test_write_then_read();
        cyc();
        host_wr_req = 1'b1; host_wr_addr = 14'h0020; host_wr_data = 16'hAAAA;
        cyc();
        host_wr_req = 1'b0;
        host_rd_req = 1'b1; host_rd_addr = 14'h0020;
        @(negedge clk);
        total++; if (mem_we !== 1'b1 || mem_addr !== 14'h0020) begin bad++; $display("FAIL wr_before_rd: got we %b addr %h want 1 0020", mem_we, mem_addr); end
        cyc();
        @(negedge clk);
        total++; if (mem_we !== 1'b0 || mem_addr !== 14'h0020) begin bad++; $display("FAIL rd_after_wr: got we %b addr %h want 0 0020", mem_we, mem_addr); end
        cyc();
        @(negedge clk);
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL wr_rd_early: got %b want 0", rd_valid); end
        cyc();
        host_rd_req = 1'b0;
        @(negedge clk);
        total++; if (rd_valid !== 1'b1 || host_rdata !== 16'hAAAA) begin bad++; $display("FAIL wr_rd_data: got v %b %h want 1 aaaa", rd_valid, host_rdata); end
    endtask

    task automatic test_wp();
        logic saw_we;
        saw_we = 1'b0;
        cyc();
        host_wr_req = 1'b1; host_wr_addr = 14'h2003; host_wr_data = 16'h5555;
        @(negedge clk);
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL wp_handshake: got %b want 1", wr_ready); end
        cyc();
        host_wr_req = 1'b0;
        @(negedge clk);
        total++; if (wp_err !== 1'b1) begin bad++; $display("FAIL wp_err_set: got %b want 1", wp_err); end
        if (mem_we) saw_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            if (mem_we) saw_we = 1'b1;
        end
        total++; if (saw_we !== 1'b0) begin bad++; $display("FAIL wp_no_write: got %b want 0", saw_we); end
        total++; if (wp_err !== 1'b1) begin bad++; $display("FAIL wp_sticky: got %b want 1", wp_err); end
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        total++; if (wp_err !== 1'b0) begin bad++; $display("FAIL wp_rst_clear: got %b want 0", wp_err); end
    endtask

    task automatic test_rst_mid_read();
        // Load host_rdata with a non-zero value first.
        cyc();
        host_rd_req = 1'b1; host_rd_addr = 14'h0020;
        cyc();
        cyc();
        host_rd_req = 1'b0;
        @(negedge clk);
        total++; if (rd_valid !== 1'b1 || host_rdata !== 16'hAAAA) begin bad++; $display("FAIL rst_pre_read: got v %b %h want 1 aaaa", rd_valid, host_rdata); end
        cyc();
        host_rd_req = 1'b1; host_rd_addr = 14'h0010;
        host_wr_req = 1'b1; host_wr_addr = 14'h0050; host_wr_data = 16'h9999;
        @(negedge clk);
        total++; if (mem_addr !== 14'h0010 || mem_we !== 1'b0) begin bad++; $display("FAIL rst_rd_issue: got addr %h we %b want 0010 0", mem_addr, mem_we); end
        cyc();
        host_rd_req = 1'b0; host_wr_req = 1'b0;
        rst = 1'b1; disp_busy = 1'b1;
        @(negedge clk);
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL rst_wr_ready: got %b want 0", wr_ready); end
        cyc();
        rst = 1'b0; disp_busy = 1'b0;
        @(negedge clk);
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_no_valid: got %b want 0", rd_valid); end
        total++; if (host_rdata !== 16'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0000", host_rdata); end
        total++; if (mem_we !== 1'b0 || wr_ready !== 1'b1) begin bad++; $display("FAIL rst_fifo_clear: got we %b rdy %b want 0 1", mem_we, wr_ready); end
        cyc();
        @(negedge clk);
        total++; if (rd_valid !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL rst_late: got v %b we %b want 0 0", rd_valid, mem_we); end
        cyc();
        host_rd_req = 1'b1; host_rd_addr = 14'h0010;
        @(negedge clk);
        total++; if (mem_addr !== 14'h0010 || mem_we !== 1'b0) begin bad++; $display("FAIL rst_idle_issue: got addr %h we %b want 0010 0", mem_addr, mem_we); end
        cyc();
        cyc();
        host_rd_req = 1'b0;
        @(negedge clk);
        total++; if (rd_valid !== 1'b1 || host_rdata !== 16'h1234) begin bad++; $display("FAIL rst_reread: got v %b %h want 1 1234", rd_valid, host_rdata); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_disp_stall();
        test_write_then_read();
        test_wp();
        test_rst_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
